uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter that serializes 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) onto `tx` at a fixed baud rate derived from the system clock. A small FIFO decouples the upstream producer, so frames can be queued and sent back-to-back. It is the transmit half of the board's serial link, paired with the existing UART receiver in the echo path.

## Interface
- `BAUD_RATE`, 9600: line rate in bit/s. Use 10000000 for short simulations.
- `CLOCK_FREQUENCY`, 100000000: `clk` frequency in Hz.
- `FIFO_DEPTH`, 4: transmit FIFO entries. Must be a power of two, ≥2.
- Derived `BAUD_CYCLE` = `CLOCK_FREQUENCY/BAUD_RATE`, using integer division. Must be ≥2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `nrst`  input  1  reset, synchronous, active-low.
- `data_in`  input  8  byte to transmit; sampled when `valid && ready`.
- `valid`  input  1  producer offers `data_in` this cycle.
- `ready`  output  1  FIFO can accept a byte this cycle.
- `tx`  output  1  serial line, idle high; registered.
- `busy`  output  1  a frame is in progress or the FIFO is non-empty.

## Operation
- Reset, sampled at a rising edge with `nrst`=0:
  - `tx`=1, FIFO emptied, shifter cleared, state=IDLE, baud counter=0.
  - Therefore `ready`=1 and `busy`=0 from the first cycle after reset.
- Handshake:
  - A byte is written to the FIFO on any edge where `valid && ready`.
  - `ready` = !full. It does not depend on a same-cycle pop, so a full FIFO never accepts a byte.
  - `valid` may be held. There is no loss and no duplication while `ready`=0.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`.
  - Occupancy counter ranges 0..`FIFO_DEPTH`.
  - A push and a pop on the same edge leave occupancy unchanged.
- State machine, with states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If the FIFO is non-empty: pop the head into the 8-bit shifter, drive `tx`=0, clear the baud counter and bit index, go to START.
  - START: hold `tx`=0 for `BAUD_CYCLE` clocks, then drive `tx`=shifter[0] and go to DATA.
  - DATA: each bit is held `BAUD_CYCLE` clocks. On each bit boundary, advance the bit index 0..7 and present the next bit. After bit 7's period, drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for `BAUD_CYCLE` clocks. At the end of the period:
    - FIFO non-empty: pop the next byte, drive `tx`=0, go directly to START. No idle gap.
    - FIFO empty: go to IDLE.
- Baud counter:
  - Counts 0..`BAUD_CYCLE`-1. The bit boundary is the edge where it equals `BAUD_CYCLE`-1; the counter then wraps to 0.
  - Width is ceil(log2(`BAUD_CYCLE`)). For the defaults that is 14 bits.
  - The counter runs only outside IDLE.
- `busy` = (state != IDLE) || FIFO non-empty. It is combinational from registered state.
- Reset mid-frame: the frame is truncated with no completion. `tx` returns to 1 on the reset edge and queued bytes are discarded.

## Timing
- Latency:
  - Byte accepted at edge N with the FIFO empty and state IDLE: `tx` falls at edge N+1.
  - The first FIFO entry goes in at edge N and is popped at edge N+1.
- Every bit, including start and stop, lasts exactly `BAUD_CYCLE` clocks. A frame lasts exactly 10×`BAUD_CYCLE` clocks.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit clock. The line stays at period 10×`BAUD_CYCLE` per byte.
- `ready`:
  - Falls on the edge where the FIFO becomes full.
  - Rises on the edge of the pop that frees an entry.
- `busy` falls on the edge that ends the final stop bit with the FIFO empty, i.e. the same edge the state returns to IDLE.
- Sustained capacity: one byte in the shifter plus `FIFO_DEPTH` queued.

## Test plan
- Reset: hold `nrst`=0 for 3 cycles with `valid`=1 → `tx`=1, `ready`=1, `busy`=0; no frame appears after release until a new handshake occurs.
- Single byte 0x55, `BAUD_RATE`=10000000 (`BAUD_CYCLE`=10):
  - `tx` falls 1 cycle after acceptance.
  - `tx` then shows the pattern 0,1,0,1,0,1,0,1,0,1 with each level held 10 clocks.
  - After 100 clocks `tx`=1 and `busy`=0.
- Burst of 6 bytes 0x01..0x06 with `valid` held, `FIFO_DEPTH`=4:
  - Bytes 1–5 are accepted on consecutive cycles, then `ready`=0.
  - Byte 6 is accepted on the cycle after byte 2 is popped.
  - The line carries 6 contiguous frames (600 clocks, no idle gap), decoded in order 0x01..0x06.
- Data coverage: send 0x00, 0xFF, 0xA3 → bench samples `tx` at each bit centre; gets 0x00, 0xFF, 0xA3 with valid start=0 and stop=1.
- Reset mid-frame: assert `nrst`=0 for 1 cycle during bit 3 of 0xF0 with 2 bytes queued → `tx`=1 the next cycle, `busy`=0, `ready`=1, and no further frames.
- Full-FIFO stall: fill the FIFO, hold `valid`=1 with changing `data_in` while `ready`=0 → only the bytes present at accepting edges are transmitted, each exactly once.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small power-of-two FIFO in front of the shifter.
// Frames are sent back-to-back while the FIFO holds data; tx idles high.
module uart_tx #(
    parameter int BAUD_RATE       = 9600,
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);
    localparam int BAUD_CYCLE = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W      = $clog2(BAUD_CYCLE);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CYCLE - 1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic push, pop, empty, full, bit_end;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == OCC_FULL);
    assign push    = valid && !full;
    assign bit_end = (cnt_q == CNT_LAST);

    assign ready = !full;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE) || !empty;

    // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes leave no gap.
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst && push) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: drives bytes through the handshake, decodes tx at bit
// centres and compares decoded frames against a queue of accepted bytes.
module tb_uart_tx;
    localparam int BC     = 10;
    localparam int BUDGET = 5000;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready, tx, busy;

    uart_tx #(.BAUD_RATE(10000000), .CLOCK_FREQUENCY(100000000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .nrst(nrst), .data_in(data_in), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         nframes = 0;
    int         rst_gen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Offers one byte with valid held; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] b, input bit scramble, output int acc);
        int t = 0;
        valid   = 1'b1;
        data_in = b;
        acc     = -1;
        while (ready !== 1'b1 && t < BUDGET) begin
            @(negedge clk);
            if (scramble) data_in = 8'($urandom);
            t++;
        end
        chk("accept_in_budget", 32'(t < BUDGET), 1);
        if (t < BUDGET) begin
            @(posedge clk);
            exp_q.push_back(data_in);
            @(negedge clk);
            acc = cyc;
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (nframes < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("frames_done", nframes, n);
    endtask

    // Line monitor: detects a start bit and samples each bit near its centre.
    int         m_st, m_g;
    logic       m_s0, m_s1;
    logic [7:0] m_d;
    initial begin
        forever begin
            @(negedge clk);
            if (nrst === 1'b1 && tx === 1'b0) begin
                m_st = cyc;
                m_g  = rst_gen;
                repeat (BC / 2 - 1) @(negedge clk);
                m_s0 = tx;
                for (int k = 0; k < 8; k++) begin
                    repeat (BC) @(negedge clk);
                    m_d[k] = tx;
                end
                repeat (BC) @(negedge clk);
                m_s1 = tx;
                if (m_g == rst_gen) begin
                    chk("start_bit", 32'(m_s0), 0);
                    chk("stop_bit", 32'(m_s1), 1);
                    chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("frame_data", 32'(m_d), 32'(exp_q.pop_front()));
                    starts.push_back(m_st);
                    nframes++;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int         acc [7];
    int         base, n0;
    logic [7:0] pat_b;
    logic       exp_bit, stayed_high;

    initial begin
        // Reset with valid asserted: nothing may be captured.
        nrst = 1'b0; valid = 1'b1; data_in = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_busy", 32'(busy), 0);
        nrst = 1'b1; valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("post_rst_frames", nframes, 0);
        chk("post_rst_tx", 32'(tx), 1);
        chk("post_rst_busy", 32'(busy), 0);

        // Single byte: exact per-clock waveform and busy fall edge.
        pat_b = 8'h55;
        send(pat_b, 1'b0, acc[0]);
        valid = 1'b0;
        chk("pre_start_tx", 32'(tx), 1);
        @(negedge clk);
        for (int i = 0; i < 10 * BC; i++) begin
            exp_bit = (i < BC) ? 1'b0 : (i >= 9 * BC) ? 1'b1 : pat_b[i / BC - 1];
            chk("wave_0x55", 32'(tx), 32'(exp_bit));
            if (i == 10 * BC - 1) chk("busy_last_stop", 32'(busy), 1);
            @(negedge clk);
        end
        chk("idle_tx", 32'(tx), 1);
        chk("idle_busy", 32'(busy), 0);
        wait_frames(1, 200);

        // Burst of six with valid held: five fill shifter+FIFO, sixth waits for a pop.
        base = starts.size();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("ready_full", 32'(ready), 0);
            send(8'(i + 1), 1'b0, acc[i]);
        end
        valid = 1'b0;
        for (int i = 1; i < 5; i++) chk("burst_consec", acc[i] - acc[0], i);
        chk("burst_sixth", acc[5] - acc[0], 10 * BC + 2);
        wait_frames(base + 6, 1000);
        for (int i = 1; i < 6; i++) chk("b2b_period", starts[base + i] - starts[base + i - 1], 10 * BC);
        repeat (20) @(negedge clk);
        chk("burst_busy", 32'(busy), 0);

        // Data coverage.
        base = nframes;
        send(8'h00, 1'b0, acc[0]);
        send(8'hFF, 1'b0, acc[1]);
        send(8'hA3, 1'b0, acc[2]);
        valid = 1'b0;
        wait_frames(base + 3, 500);
        repeat (20) @(negedge clk);

        // Reset during data bit 3 of 0xF0 with two bytes queued.
        send(8'hF0, 1'b0, acc[0]);
        send(8'h11, 1'b0, acc[1]);
        send(8'h22, 1'b0, acc[2]);
        valid = 1'b0;
        repeat (43) @(negedge clk);
        nrst = 1'b0;
        rst_gen++;
        exp_q.delete();
        @(negedge clk);
        nrst = 1'b1;
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(ready), 1);
        n0 = nframes;
        stayed_high = 1'b1;
        repeat (300) begin
            @(negedge clk);
            stayed_high &= tx;
        end
        chk("midrst_line_idle", 32'(stayed_high), 1);
        chk("midrst_no_frames", nframes, n0);

        // Full-FIFO stall: data_in churns while ready is low.
        n0 = nframes;
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 1'b0, acc[i]);
        send(8'hC6, 1'b1, acc[5]);
        send(8'hC7, 1'b1, acc[6]);
        valid = 1'b0;
        wait_frames(n0 + 7, 1200);
        repeat (200) @(negedge clk);
        chk("stall_no_dup", nframes, n0 + 7);
        chk("sb_drained", exp_q.size(), 0);
        chk("final_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
